beep_seq_sched: RTL and testbench
=================================

// Module: beep_seq_sched
// PURPOSE
// - Tone scheduler between the UART command decoder and the PWM beep engine.
// - Queues decoded tone commands (period, high time, repeat count) and issues them one at a time.
// - Starts the next tone only after the engine reports completion and a fixed silent gap has elapsed.
// - Adds flush, overflow reporting and a watchdog so a hung engine cannot stall the queue.
// PARAMETERS
// - DEPTH          8            queue entries; power of two, >=2
// - GAP_CYCLES     2_500_000    silent clocks between tones (50 ms @ 50 MHz); 0 = no gap
// - TIMEOUT_CYCLES 500_000_000  max clocks waiting for i_beep_done before abort (10 s @ 50 MHz)
// PORTS
// - i_clk          in   1      system clock (50 MHz)
// - i_rst          in   1      reset: one clock; asynchronous, active-high
// - i_cmd_en       in   1      1-cycle strobe: a tone command is valid
// - i_cmd_periord  in   32     PWM period in clocks
// - i_cmd_high     in   32     PWM high time in clocks
// - i_cmd_num      in   16     number of PWM periods to play
// - i_flush        in   1      1-cycle strobe: discard all queued tones
// - i_beep_done    in   1      1-cycle strobe from the beep engine: current tone finished
// - o_beep_en      out  1      1-cycle start strobe to the beep engine
// - o_beep_periord out  32     tone period; held stable from o_beep_en until next start
// - o_beep_high    out  32     tone high time; held stable, same rule as o_beep_periord
// - o_beep_num     out  16     tone repeat count; held stable, same rule as o_beep_periord
// - o_busy         out  1      1 in any state except IDLE
// - o_level        out  clog2(DEPTH)+1  current queue occupancy
// - o_cmd_drop     out  1      1-cycle pulse: command discarded (queue full, or flush in same cycle)
// - o_timeout      out  1      1-cycle pulse: watchdog expired in PLAY
// BEHAVIOUR
// - Reset: state=IDLE, queue empty; all outputs 0; o_beep_* fields = 0.
// - Push rule:
//   - i_cmd_en with level<DEPTH writes the entry; occupancy rises next cycle.
//   - When full, the push is accepted only if a pop occurs in the same cycle; otherwise o_cmd_drop pulses.
// - FSM states: IDLE, LOAD, START, PLAY, GAP.
//   - IDLE: queue non-empty -> LOAD.
//   - LOAD: pop the head and register the fields.
//     - If num==0 or periord==0, the entry is skipped: -> IDLE, or -> LOAD again if more entries remain.
//     - Otherwise -> START.
//   - START: o_beep_en=1 for exactly one cycle -> PLAY.
//   - PLAY:
//     - Watchdog counts from 0. i_beep_done -> GAP.
//     - Watchdog reaching TIMEOUT_CYCLES-1 -> o_timeout pulses -> GAP.
//     - i_beep_done in the START cycle is ignored.
//   - GAP: count GAP_CYCLES clocks -> IDLE. GAP_CYCLES==0 skips GAP (PLAY -> IDLE directly).
// - Latency: push at cycle N into an empty queue while IDLE -> LOAD at N+1, o_beep_en high at N+2.
// - Clamp: if high > periord, o_beep_high = periord. All other fields pass through unmodified.
// - Flush:
//   - Empties the queue next cycle; o_level=0.
//   - A tone already in START/PLAY/GAP completes normally; no new tone starts afterwards.
//   - Flush and push in the same cycle: flush wins, the command is discarded, o_cmd_drop pulses.
// - Simultaneous i_beep_done and watchdog expiry: treated as done; o_timeout stays 0.
// - Reset mid-tone: immediate return to reset values; the engine is not sent a stop command.
// - Counters: watchdog is 32 bit, gap counter is 32 bit; both saturate and never wrap.
// STRUCTURE
// - Shared package/include beep_pkg:
//   - FSM state encodings
//   - field widths: PERIORD_W=32, HIGH_W=32, NUM_W=16
//   - entry width ENTRY_W=80 and the packing order {periord, high, num}
// - Sub-module beep_cmd_fifo: synchronous FIFO, width ENTRY_W, depth DEPTH.
//   - Ports: push, pop, flush, full, empty, level.
//   - First-word-fall-through head output.
// - The top level holds the FSM, watchdog and gap counters, clamp logic and output registers.
// TESTING (DEPTH=4, GAP_CYCLES=10, TIMEOUT_CYCLES=1000)
// - Single tone:
//   - Push {1000, 500, 3} at cycle N -> o_beep_en at N+2 with fields 1000/500/3; o_busy=1.
//   - Assert done -> GAP for 10 clocks -> IDLE; o_busy=0.
// - Back-to-back:
//   - Push 3 tones -> each o_beep_en occurs exactly 12 clocks after the previous done (1 GAP-exit + 1 LOAD).
//   - Order is preserved; o_level counts down 3,2,1,0.
// - Overflow: push 6 tones while engine busy -> 4 queued, o_cmd_drop pulses twice, o_level=4.
// - Flush mid-play:
//   - During PLAY with 3 queued, pulse i_flush -> o_level=0 next cycle.
//   - After done+gap -> IDLE; no further o_beep_en.
// - Watchdog: never assert done -> o_timeout pulses 1000 clocks after START, then GAP, then next tone.
// - Edge entries:
//   - Push {0, 5, 4} and {100, 200, 0} -> both skipped, no o_beep_en.
//   - Push {100, 200, 4} -> o_beep_high=100 (clamped).
// - Async reset: assert i_rst mid-PLAY -> all outputs 0 immediately, queue empty.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared definitions for the tone scheduler: FSM encoding, field widths and
// the layout of one queued tone command.
package beep_pkg;

  localparam int PERIORD_W = 32;
  localparam int HIGH_W    = 32;
  localparam int NUM_W     = 16;
  localparam int ENTRY_W   = PERIORD_W + HIGH_W + NUM_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Queue entries are packed as {periord, high, num}, periord in the MSBs.
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [PERIORD_W-1:0] periord,
    input logic [HIGH_W-1:0]    high,
    input logic [NUM_W-1:0]     num
  );
    return {periord, high, num};
  endfunction

endpackage

// File: rtl/beep_cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head and a flush
// that empties it in one clock. A push into a full FIFO succeeds only with a pop.
module beep_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 80,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == LW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign level   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/beep_seq_sched.sv
// Tone scheduler: queues tone commands and hands them one at a time to the
// PWM beep engine, with a silent gap between tones and a completion watchdog.
module beep_seq_sched
  import beep_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned GAP_CYCLES     = 2_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_en,
  input  logic [PERIORD_W-1:0] i_cmd_periord,
  input  logic [HIGH_W-1:0]    i_cmd_high,
  input  logic [NUM_W-1:0]     i_cmd_num,
  input  logic                 i_flush,
  input  logic                 i_beep_done,
  output logic                 o_beep_en,
  output logic [PERIORD_W-1:0] o_beep_periord,
  output logic [HIGH_W-1:0]    o_beep_high,
  output logic [NUM_W-1:0]     o_beep_num,
  output logic                 o_busy,
  output logic [LW-1:0]        o_level,
  output logic                 o_cmd_drop,
  output logic                 o_timeout
);

  localparam logic [31:0] WD_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam bit          HAS_GAP  = (GAP_CYCLES != 0);

  state_t state_reg, state_next;
  state_t dispatch_state;

  logic [ENTRY_W-1:0]   cmd_entry;
  logic [ENTRY_W-1:0]   head;
  logic [PERIORD_W-1:0] head_periord;
  logic [HIGH_W-1:0]    head_high;
  logic [NUM_W-1:0]     head_num;
  logic [HIGH_W-1:0]    clamped_high;
  logic                 head_skip;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LW-1:0]        fifo_level;
  logic                 pop;
  logic                 push_ok;
  logic                 more_queued;
  logic                 load_en;
  logic                 timeout;

  logic [31:0]          wd_reg;
  logic [31:0]          gap_reg;
  logic [PERIORD_W-1:0] periord_reg;
  logic [HIGH_W-1:0]    high_reg;
  logic [NUM_W-1:0]     num_reg;
  logic                 drop_reg;

  assign cmd_entry = pack_entry(i_cmd_periord, i_cmd_high, i_cmd_num);
  assign {head_periord, head_high, head_num} = head;
  assign head_skip    = (head_num == '0) || (head_periord == '0);
  assign clamped_high = (head_high > head_periord) ? head_periord : head_high;

  // Flush beats a same-cycle push; a full queue takes a push only alongside a pop.
  assign pop     = (state_reg == ST_LOAD) && !fifo_empty;
  assign push_ok = i_cmd_en && !i_flush && (!fifo_full || pop);

  // Shared exit decision for IDLE, skipped entries and the end of a tone:
  // go straight to LOAD when something is (or is about to be) queued.
  assign dispatch_state = ((!fifo_empty && !i_flush) || push_ok) ? ST_LOAD : ST_IDLE;
  assign more_queued    = ((fifo_level > LW'(1)) && !i_flush) || push_ok;

  beep_cmd_fifo #(
    .DEPTH (int'(DEPTH)),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push_ok),
    .pop   (pop),
    .flush (i_flush),
    .din   (cmd_entry),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      ST_IDLE: state_next = dispatch_state;
      ST_LOAD: begin
        if (fifo_empty) begin
          state_next = ST_IDLE;
        end else if (head_skip) begin
          state_next = more_queued ? ST_LOAD : ST_IDLE;
        end else begin
          load_en    = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: state_next = ST_PLAY;
      ST_PLAY: begin
        // Done wins over a watchdog expiry in the same cycle.
        if (i_beep_done) begin
          state_next = HAS_GAP ? ST_GAP : dispatch_state;
        end else if (wd_reg == WD_LAST) begin
          timeout    = 1'b1;
          state_next = HAS_GAP ? ST_GAP : dispatch_state;
        end
      end
      ST_GAP: begin
        if (gap_reg >= GAP_LAST) begin
          state_next = dispatch_state;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Both counters restart on state entry and saturate rather than wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_reg  <= '0;
      gap_reg <= '0;
    end else begin
      if (state_reg == ST_PLAY) begin
        wd_reg <= (wd_reg != '1) ? wd_reg + 32'd1 : wd_reg;
      end else begin
        wd_reg <= '0;
      end
      if (state_reg == ST_GAP) begin
        gap_reg <= (gap_reg != '1) ? gap_reg + 32'd1 : gap_reg;
      end else begin
        gap_reg <= '0;
      end
    end
  end

  // Fields change only when a real tone is loaded, so they stay stable
  // from its start strobe until the next one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      periord_reg <= '0;
      high_reg    <= '0;
      num_reg     <= '0;
      drop_reg    <= 1'b0;
    end else begin
      if (load_en) begin
        periord_reg <= head_periord;
        high_reg    <= clamped_high;
        num_reg     <= head_num;
      end
      drop_reg <= i_cmd_en && !push_ok;
    end
  end

  assign o_beep_en      = (state_reg == ST_START);
  assign o_beep_periord = periord_reg;
  assign o_beep_high    = high_reg;
  assign o_beep_num     = num_reg;
  assign o_busy         = (state_reg != ST_IDLE);
  assign o_level        = fifo_level;
  assign o_cmd_drop     = drop_reg;
  assign o_timeout      = timeout;

endmodule

// File: tb/tb_beep_seq_sched.sv
// Directed bench for beep_seq_sched: stimulus pushes expected tones into a
// scoreboard, a negedge monitor checks every start strobe against it.
module tb_beep_seq_sched;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cmd_en = 1'b0;
  logic [31:0] i_cmd_periord = '0;
  logic [31:0] i_cmd_high = '0;
  logic [15:0] i_cmd_num = '0;
  logic        i_flush = 1'b0;
  logic        i_beep_done = 1'b0;
  logic        o_beep_en;
  logic [31:0] o_beep_periord;
  logic [31:0] o_beep_high;
  logic [15:0] o_beep_num;
  logic        o_busy;
  logic [2:0]  o_level;
  logic        o_cmd_drop;
  logic        o_timeout;

  beep_seq_sched #(
    .DEPTH          (4),
    .GAP_CYCLES     (10),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_cmd_en       (i_cmd_en),
    .i_cmd_periord  (i_cmd_periord),
    .i_cmd_high     (i_cmd_high),
    .i_cmd_num      (i_cmd_num),
    .i_flush        (i_flush),
    .i_beep_done    (i_beep_done),
    .o_beep_en      (o_beep_en),
    .o_beep_periord (o_beep_periord),
    .o_beep_high    (o_beep_high),
    .o_beep_num     (o_beep_num),
    .o_busy         (o_busy),
    .o_level        (o_level),
    .o_cmd_drop     (o_cmd_drop),
    .o_timeout      (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] p;
    logic [31:0] h;
    logic [15:0] n;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int starts_seen = 0;
  int last_start_cyc = 0;
  int timeout_cnt = 0;
  int last_timeout_cyc = 0;
  int drop_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every start strobe consumes one scoreboard entry.
  always @(negedge i_clk) begin : mon
    exp_t e;
    if (!i_rst) begin
      if (o_beep_en) begin
        starts_seen++;
        last_start_cyc = cyc;
        $display("start #%0d cycle %0d periord=%0d high=%0d num=%0d level=%0d",
                 starts_seen, cyc, o_beep_periord, o_beep_high, o_beep_num, o_level);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start: got a start strobe expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("start_periord", 64'(o_beep_periord), 64'(e.p));
          chk("start_high", 64'(o_beep_high), 64'(e.h));
          chk("start_num", 64'(o_beep_num), 64'(e.n));
        end
      end
      if (o_timeout) begin
        timeout_cnt++;
        last_timeout_cyc = cyc;
        $display("timeout cycle %0d", cyc);
      end
      if (o_cmd_drop) begin
        drop_cnt++;
        $display("drop cycle %0d", cyc);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic push_cmd(input logic [31:0] p, input logic [31:0] h, input logic [15:0] n,
                          input bit plays, input logic [31:0] exp_h);
    i_cmd_periord = p;
    i_cmd_high    = h;
    i_cmd_num     = n;
    i_cmd_en      = 1'b1;
    if (plays) sb.push_back('{p, exp_h, n});
    tick();
    i_cmd_en = 1'b0;
  endtask

  task automatic pulse_done();
    i_beep_done = 1'b1;
    tick();
    i_beep_done = 1'b0;
  endtask

  task automatic wait_next(input int budget);
    int target;
    target = starts_seen + 1;
    while (starts_seen < target && budget > 0) begin
      tick();
      budget--;
    end
    if (starts_seen < target) begin
      checks++;
      failures++;
      $display("FAIL wait_start: got %0d starts expected %0d", starts_seen, target);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int n0, d0, s0, t0, dc0, st0, b;

    // Reset values
    ticks(3);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_level", 64'(o_level), 64'd0);
    chk("rst_beep_en", 64'(o_beep_en), 64'd0);
    chk("rst_periord", 64'(o_beep_periord), 64'd0);
    chk("rst_high", 64'(o_beep_high), 64'd0);
    chk("rst_num", 64'(o_beep_num), 64'd0);
    chk("rst_drop", 64'(o_cmd_drop), 64'd0);
    chk("rst_timeout", 64'(o_timeout), 64'd0);
    i_rst = 1'b0;
    ticks(2);

    // Single tone: start two cycles after the push, 10-cycle gap afterwards
    n0 = cyc;
    push_cmd(32'd1000, 32'd500, 16'd3, 1'b1, 32'd500);
    wait_next(20);
    chk("t1_start_latency", 64'(last_start_cyc - n0), 64'd2);
    chk("t1_busy_play", 64'(o_busy), 64'd1);
    pulse_done();
    ticks(9);
    chk("t1_busy_gap", 64'(o_busy), 64'd1);
    tick();
    chk("t1_idle", 64'(o_busy), 64'd0);

    // Back-to-back: three tones queued behind a playing one
    push_cmd(32'd500, 32'd100, 16'd2, 1'b1, 32'd100);
    wait_next(20);
    push_cmd(32'd200, 32'd50, 16'd1, 1'b1, 32'd50);
    push_cmd(32'd300, 32'd400, 16'd2, 1'b1, 32'd300);
    push_cmd(32'd400, 32'd100, 16'd5, 1'b1, 32'd100);
    chk("b2b_level3", 64'(o_level), 64'd3);
    for (int k = 0; k < 3; k++) begin
      d0 = cyc;
      pulse_done();
      wait_next(40);
      chk("b2b_spacing", 64'(last_start_cyc - d0), 64'd12);
      chk("b2b_level", 64'(o_level), 64'(2 - k));
    end
    pulse_done();
    ticks(10);
    chk("b2b_idle", 64'(o_busy), 64'd0);

    // Overflow: six pushes while busy, four fit
    push_cmd(32'd600, 32'd300, 16'd1, 1'b1, 32'd300);
    wait_next(20);
    dc0 = drop_cnt;
    push_cmd(32'd11, 32'd1, 16'd1, 1'b1, 32'd1);
    push_cmd(32'd12, 32'd2, 16'd1, 1'b1, 32'd2);
    push_cmd(32'd13, 32'd3, 16'd1, 1'b1, 32'd3);
    push_cmd(32'd14, 32'd4, 16'd1, 1'b1, 32'd4);
    push_cmd(32'd15, 32'd5, 16'd1, 1'b0, 32'd0);
    push_cmd(32'd16, 32'd6, 16'd1, 1'b0, 32'd0);
    tick();
    chk("ovf_drops", 64'(drop_cnt - dc0), 64'd2);
    chk("ovf_level", 64'(o_level), 64'd4);

    // Flush mid-play: queue empties, current tone finishes, nothing follows
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    sb.delete();
    chk("flush_level", 64'(o_level), 64'd0);
    chk("flush_busy", 64'(o_busy), 64'd1);
    pulse_done();
    ticks(10);
    chk("flush_idle", 64'(o_busy), 64'd0);
    st0 = starts_seen;
    ticks(20);
    chk("flush_no_start", 64'(starts_seen), 64'(st0));

    // Flush and push in the same cycle: push discarded
    dc0 = drop_cnt;
    i_cmd_periord = 32'd100;
    i_cmd_high    = 32'd10;
    i_cmd_num     = 16'd1;
    i_cmd_en      = 1'b1;
    i_flush       = 1'b1;
    tick();
    i_cmd_en = 1'b0;
    i_flush  = 1'b0;
    tick();
    chk("flushpush_drop", 64'(drop_cnt - dc0), 64'd1);
    chk("flushpush_level", 64'(o_level), 64'd0);
    chk("flushpush_busy", 64'(o_busy), 64'd0);

    // Watchdog: no done -> timeout 1000 clocks after start, then next tone
    push_cmd(32'd700, 32'd350, 16'd2, 1'b1, 32'd350);
    push_cmd(32'd800, 32'd100, 16'd1, 1'b1, 32'd100);
    wait_next(20);
    s0 = last_start_cyc;
    t0 = timeout_cnt;
    b = 1100;
    while (timeout_cnt == t0 && b > 0) begin
      tick();
      b--;
    end
    chk("wd_count", 64'(timeout_cnt - t0), 64'd1);
    chk("wd_delay", 64'(last_timeout_cyc - s0), 64'd1000);
    wait_next(40);
    chk("wd_next_start", 64'(last_start_cyc - last_timeout_cyc), 64'd12);

    // Done in the very cycle the watchdog would expire: no timeout
    s0 = last_start_cyc;
    t0 = timeout_cnt;
    while (cyc < s0 + 1000) tick();
    pulse_done();
    ticks(5);
    chk("wd_tie_no_timeout", 64'(timeout_cnt - t0), 64'd0);
    chk("wd_tie_gap", 64'(o_busy), 64'd1);
    ticks(10);
    chk("wd_tie_idle", 64'(o_busy), 64'd0);

    // Edge entries: zero period / zero count skipped, high clamped
    st0 = starts_seen;
    push_cmd(32'd0, 32'd5, 16'd4, 1'b0, 32'd0);
    push_cmd(32'd100, 32'd200, 16'd0, 1'b0, 32'd0);
    ticks(20);
    chk("skip_no_start", 64'(starts_seen), 64'(st0));
    chk("skip_idle", 64'(o_busy), 64'd0);
    chk("skip_level", 64'(o_level), 64'd0);
    push_cmd(32'd100, 32'd200, 16'd4, 1'b1, 32'd100);
    wait_next(20);
    pulse_done();
    ticks(11);
    chk("clamp_idle", 64'(o_busy), 64'd0);

    // Asynchronous reset mid-play
    push_cmd(32'd900, 32'd450, 16'd2, 1'b1, 32'd450);
    push_cmd(32'd50, 32'd20, 16'd1, 1'b1, 32'd20);
    wait_next(20);
    chk("arst_pre_level", 64'(o_level), 64'd1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_busy", 64'(o_busy), 64'd0);
    chk("arst_level", 64'(o_level), 64'd0);
    chk("arst_beep_en", 64'(o_beep_en), 64'd0);
    chk("arst_periord", 64'(o_beep_periord), 64'd0);
    chk("arst_high", 64'(o_beep_high), 64'd0);
    chk("arst_num", 64'(o_beep_num), 64'd0);
    sb.delete();
    tick();
    i_rst = 1'b0;
    st0 = starts_seen;
    ticks(20);
    chk("arst_no_start", 64'(starts_seen), 64'(st0));
    chk("arst_level_after", 64'(o_level), 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
